// File: rtl/mips8_ctrl_if.sv
// mips8_ctrl_if: control-unit <-> datapath bundle for the 8-bit MIPS core.
//   master : the control FSM (drives enables/selects, receives opcode/flags)
//   slave  : the datapath / memory side (or a testbench standing in for it)
// Inputs to the controller : start, opcode, funct, zero, mem_ready
// Outputs of the controller: pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src_b,
//                            ext_sel, alu_op, mem_rd, mem_wr, mem_to_reg,
//                            halted, trap, retired
interface mips8_ctrl_if #(
    parameter int RETIRE_W = 8
);
    logic                start;
    logic [3:0]          opcode;
    logic [2:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                ir_we;
    logic                reg_we;
    logic                reg_dst;
    logic                alu_src_b;
    logic                ext_sel;
    logic [2:0]          alu_op;
    logic                mem_rd;
    logic                mem_wr;
    logic                mem_to_reg;
    logic                halted;
    logic                trap;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  start, opcode, funct, zero, mem_ready,
        output pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src_b, ext_sel,
               alu_op, mem_rd, mem_wr, mem_to_reg, halted, trap, retired
    );

    modport slave (
        output start, opcode, funct, zero, mem_ready,
        input  pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src_b, ext_sel,
               alu_op, mem_rd, mem_wr, mem_to_reg, halted, trap, retired
    );
endinterface

// File: rtl/mips8_ctrl_fsm.sv
// mips8_ctrl_fsm: multi-cycle control unit for the 8-bit MIPS datapath.
// Ports: clk (rising edge), rst_n (async, active low), bus (mips8_ctrl_if.master)
// carrying the opcode/flag inputs and every datapath enable/select output.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | load IR, PC <= PC+1
// DECODE   | dispatch on opcode
// EXEC_R   | R-type ALU op (alu_op = funct)
// WB_R     | write rd, retire
// EXEC_I   | immediate ALU op
// WB_I     | write rt, retire
// ADDR     | effective address = rs + sext(imm)
// MEM_RD   | load strobe, wait for mem_ready
// MEM_WR   | store strobe, wait for mem_ready (retire on ready)
// WB_MEM   | write loaded data, retire
// BRANCH   | compare, conditional PC load, retire
// JUMP     | PC <= jump target, retire
// HALT     | stopped (retired on entry), reset only
// TRAP     | illegal opcode / memory timeout, reset only
module mips8_ctrl_fsm #(
    parameter int RETIRE_W     = 8,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mips8_ctrl_if.master  bus
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT, S_TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                retire;

    logic       pc_we, ir_we, reg_we, reg_dst, alu_src_b, ext_sel;
    logic       mem_rd, mem_wr, mem_to_reg, halted, trap;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [2:0] imm_alu_op;

    assign imm_alu_op = (bus.opcode == OP_ANDI) ? 3'b010 :
                        (bus.opcode == OP_ORI)  ? 3'b011 : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        retire     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        alu_src_b  = 1'b0;
        ext_sel    = 1'b0;
        alu_op     = 3'b000;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:                      state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    OP_LW, OP_SW:              state_d = S_ADDR;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_op  = bus.funct;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                alu_op  = bus.funct;
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_I, S_WB_I: begin
                alu_src_b = 1'b1;
                ext_sel   = (bus.opcode == OP_ADDI);
                alu_op    = imm_alu_op;
                if (state_q == S_WB_I) begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_ADDR: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                mem_rd    = (state_q == S_MEM_RD);
                mem_wr    = (state_q == S_MEM_WR);
                if (bus.mem_ready) begin
                    wait_d = '0;
                    if (state_q == S_MEM_RD) begin
                        state_d = S_WB_MEM;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                    // this is the MEM_WAIT_MAX-th cycle without ready
                    wait_d  = '0;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op  = 3'b001;
                ext_sel = 1'b1;
                pc_src  = 2'b01;
                // the only Mealy term: taken = zero for BEQ, !zero for BNE
                pc_we   = bus.zero ^ (bus.opcode == OP_BNE);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = 2'b10;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_TRAP: begin
                halted = 1'b1;
                trap   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pc_we      = pc_we;
    assign bus.pc_src     = pc_src;
    assign bus.ir_we      = ir_we;
    assign bus.reg_we     = reg_we;
    assign bus.reg_dst    = reg_dst;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_sel    = ext_sel;
    assign bus.alu_op     = alu_op;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.halted     = halted;
    assign bus.trap       = trap;
    assign bus.retired    = retired_q;
endmodule
